// File: rtl/risc16b_mem_arbiter_if.sv
// rtl/risc16b_mem_arbiter_if.sv - core instruction/data ports and SRAM port bundled for the risc16b memory arbiter
interface risc16b_mem_arbiter_if;
    logic [15:0] i_addr;
    logic        i_oe;
    logic [15:0] i_din;
    logic        i_ready;

    logic [15:0] d_addr;
    logic        d_oe;
    logic [1:0]  d_we;
    logic [15:0] d_dout;
    logic [15:0] d_din;
    logic        d_ready;

    logic [14:0] m_addr;
    logic        m_en;
    logic [1:0]  m_we;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;

    modport slave (
        input  i_addr, i_oe, d_addr, d_oe, d_we, d_dout, m_rdata,
        output i_din, i_ready, d_din, d_ready, m_addr, m_en, m_we, m_wdata
    );

    modport master (
        output i_addr, i_oe, d_addr, d_oe, d_we, d_dout, m_rdata,
        input  i_din, i_ready, d_din, d_ready, m_addr, m_en, m_we, m_wdata
    );
endinterface

// File: rtl/risc16b_mem_arbiter.sv
// rtl/risc16b_mem_arbiter.sv - shares one SRAM between risc16b I/D ports, decodes the I/O page LED register
// Optional ARB_ROUND_ROBIN_EN: round-robin arbitration on conflicts instead of fixed data priority.
module risc16b_mem_arbiter #(
    parameter logic [7:0]  IO_PAGE   = 8'h7f,
    parameter logic [15:0] LED_RESET = 16'h0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    risc16b_mem_arbiter_if.slave    bus,
    output logic [15:0]             led
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t      state_q, state_d;
    logic        io_q, io_d;
    logic        wr_q, wr_d;
    logic [15:0] led_q, led_d;
    logic        d_req, i_req, d_io, i_io, d_wr, led_sel;
    logic        grant_d, grant_i;
    logic        unused_addr_bits;

    assign d_req   = bus.d_oe | (|bus.d_we);
    assign i_req   = bus.i_oe;
    assign d_wr    = |bus.d_we;
    assign d_io    = (bus.d_addr[15:8] == IO_PAGE);
    assign i_io    = (bus.i_addr[15:8] == IO_PAGE);
    assign led_sel = (bus.d_addr[7:1] == 7'd0);
    assign led     = led_q;
    assign unused_addr_bits = bus.i_addr[0] ^ bus.d_addr[0];

`ifdef ARB_ROUND_ROBIN_EN
    // ptr: 0 = data port wins the next conflict, 1 = instruction port wins
    logic ptr_q, ptr_d;

    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        ptr_d   = ptr_q;
        if (state_q == IDLE && rst_n) begin
            if (d_req && i_req) begin
                grant_d = ~ptr_q;
                grant_i = ptr_q;
                ptr_d   = ~ptr_q;
            end else begin
                grant_d = d_req;
                grant_i = i_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_q == IDLE && rst_n) begin
            grant_d = d_req;
            grant_i = i_req & ~d_req;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        io_d        = io_q;
        wr_d        = wr_q;
        led_d       = led_q;
        bus.m_en    = 1'b0;
        bus.m_addr  = 15'd0;
        bus.m_we    = 2'b00;
        bus.m_wdata = 16'd0;
        bus.i_ready = 1'b0;
        bus.i_din   = 16'd0;
        bus.d_ready = 1'b0;
        bus.d_din   = 16'd0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUSY_D;
                    io_d    = d_io;
                    wr_d    = d_wr;
                    if (!d_io) begin
                        bus.m_en    = 1'b1;
                        bus.m_addr  = bus.d_addr[15:1];
                        bus.m_we    = bus.d_we;
                        bus.m_wdata = d_wr ? bus.d_dout : 16'd0;
                    end else if (led_sel) begin
                        if (bus.d_we[0]) led_d[15:8] = bus.d_dout[15:8];
                        if (bus.d_we[1]) led_d[7:0]  = bus.d_dout[7:0];
                    end
                end else if (grant_i) begin
                    state_d = BUSY_I;
                    io_d    = i_io;
                    wr_d    = 1'b0;
                    if (!i_io) begin
                        bus.m_en   = 1'b1;
                        bus.m_addr = bus.i_addr[15:1];
                    end
                end
            end
            BUSY_I: begin
                bus.i_ready = 1'b1;
                bus.i_din   = io_q ? 16'd0 : bus.m_rdata;
                state_d     = IDLE;
            end
            BUSY_D: begin
                bus.d_ready = 1'b1;
                // Requester holds d_addr, so the I/O read can decode it live
                if (!wr_q) bus.d_din = io_q ? (led_sel ? led_q : 16'd0) : bus.m_rdata;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            io_q    <= 1'b0;
            wr_q    <= 1'b0;
            led_q   <= LED_RESET;
        end else begin
            state_q <= state_d;
            io_q    <= io_d;
            wr_q    <= wr_d;
            led_q   <= led_d;
        end
    end
endmodule

// File: tb/tb_risc16b_mem_arbiter.sv
// tb/tb_risc16b_mem_arbiter.sv - self-checking bench for risc16b_mem_arbiter with SRAM model and reference model
module tb_risc16b_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] led;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    risc16b_mem_arbiter_if bus();

    risc16b_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus), .led(led));

    logic [7:0]  sram    [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] ref_led;
    bit          ref_ptr;

    always @(posedge clk) begin
        if (bus.m_en) begin
            bus.m_rdata <= {sram[{bus.m_addr, 1'b0}], sram[{bus.m_addr, 1'b1}]};
            if (bus.m_we[0]) sram[{bus.m_addr, 1'b0}] <= bus.m_wdata[15:8];
            if (bus.m_we[1]) sram[{bus.m_addr, 1'b1}] <= bus.m_wdata[7:0];
        end
    end

    function automatic bit is_io(input logic [15:0] a);
        return a[15:8] == 8'h7f;
    endfunction

    function automatic logic [15:0] exp_read(input bit is_d, input logic [15:0] a);
        if (is_io(a)) return (is_d && a[7:1] == 7'd0) ? ref_led : 16'h0000;
        return {ref_mem[{a[15:1], 1'b0}], ref_mem[{a[15:1], 1'b1}]};
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [1:0] we, input logic [15:0] v);
        if (is_io(a)) begin
            if (a[7:1] == 7'd0) begin
                if (we[0]) ref_led[15:8] = v[15:8];
                if (we[1]) ref_led[7:0]  = v[7:0];
            end
        end else begin
            if (we[0]) ref_mem[{a[15:1], 1'b0}] = v[15:8];
            if (we[1]) ref_mem[{a[15:1], 1'b1}] = v[7:0];
        end
    endfunction

    task automatic access(input bit is_d, input logic [15:0] addr, input bit oe, input logic [1:0] we,
                          input logic [15:0] dout, output logic men, output logic [14:0] maddr,
                          output logic [1:0] mwe, output logic [15:0] mwdata, output int lat,
                          output logic [15:0] din);
        @(negedge clk);
        if (is_d) begin
            bus.d_addr = addr; bus.d_oe = oe; bus.d_we = we; bus.d_dout = dout;
        end else begin
            bus.i_addr = addr; bus.i_oe = 1'b1;
        end
        #1;
        men = bus.m_en; maddr = bus.m_addr; mwe = bus.m_we; mwdata = bus.m_wdata;
        lat = 0; din = 16'hxxxx;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (is_d ? bus.d_ready : bus.i_ready) begin
                lat = k;
                din = is_d ? bus.d_din : bus.i_din;
                break;
            end
        end
        bus.d_oe = 1'b0; bus.d_we = 2'b00; bus.i_oe = 1'b0;
    endtask

    logic        o_men;
    logic [14:0] o_maddr;
    logic [1:0]  o_mwe;
    logic [15:0] o_mwdata, o_din, exp;
    int          o_lat;

    task automatic test_reset();
        vectors++;
        if ({bus.i_ready, bus.d_ready, bus.i_din, bus.d_din} !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_port_outputs: got %h/%h/%h/%h need all zero", bus.i_ready, bus.d_ready, bus.i_din, bus.d_din);
        end
        vectors++;
        if ({bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata} !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_mem_outputs: got en=%b we=%b addr=%h wdata=%h need zero", bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata);
        end
        vectors++;
        if (led !== 16'h0000) begin
            miscompares++; $display("FAIL reset_led: got %h need 0000", led);
        end
    endtask

    task automatic test_fetch();
        sram[16'h0010] = 8'h12; ref_mem[16'h0010] = 8'h12;
        sram[16'h0011] = 8'h34; ref_mem[16'h0011] = 8'h34;
        access(1'b0, 16'h0011, 1'b0, 2'b00, 16'h0, o_men, o_maddr, o_mwe, o_mwdata, o_lat, o_din);
        vectors++;
        if (o_men !== 1'b1 || o_maddr !== 15'h0008) begin
            miscompares++; $display("FAIL fetch_mem_drive: got en=%b addr=%h need 1/0008", o_men, o_maddr);
        end
        vectors++;
        if (o_lat !== 1 || o_din !== 16'h1234) begin
            miscompares++; $display("FAIL fetch_data: got lat=%0d din=%h need 1/1234", o_lat, o_din);
        end
        #1;
        @(negedge clk);
        vectors++;
        if (bus.i_ready !== 1'b0 || bus.i_din !== 16'h0) begin
            miscompares++; $display("FAIL fetch_ready_pulse: got ready=%b din=%h need 0/0000", bus.i_ready, bus.i_din);
        end
    endtask

    task automatic test_byte_write();
        sram[16'h0021] = 8'h5a; ref_mem[16'h0021] = 8'h5a;
        access(1'b1, 16'h0020, 1'b0, 2'b01, 16'hABCD, o_men, o_maddr, o_mwe, o_mwdata, o_lat, o_din);
        model_write(16'h0020, 2'b01, 16'hABCD);
        vectors++;
        if (o_men !== 1'b1 || o_mwe !== 2'b01 || o_mwdata !== 16'hABCD || o_lat !== 1) begin
            miscompares++;
            $display("FAIL byte_write: got en=%b we=%b wdata=%h lat=%0d need 1/01/abcd/1", o_men, o_mwe, o_mwdata, o_lat);
        end
        access(1'b1, 16'h0021, 1'b1, 2'b00, 16'h0, o_men, o_maddr, o_mwe, o_mwdata, o_lat, o_din);
        vectors++;
        if (o_din !== 16'hAB5A || o_mwe !== 2'b00) begin
            miscompares++; $display("FAIL byte_write_readback: got din=%h we=%b need ab5a/00", o_din, o_mwe);
        end
    endtask

    task automatic test_io();
        access(1'b1, 16'h7f00, 1'b0, 2'b11, 16'h00FF, o_men, o_maddr, o_mwe, o_mwdata, o_lat, o_din);
        model_write(16'h7f00, 2'b11, 16'h00FF);
        vectors++;
        if (o_men !== 1'b0 || o_mwe !== 2'b00 || o_lat !== 1 || led !== 16'h00FF) begin
            miscompares++;
            $display("FAIL io_led_write: got en=%b we=%b lat=%0d led=%h need 0/00/1/00ff", o_men, o_mwe, o_lat, led);
        end
        access(1'b1, 16'h7f01, 1'b1, 2'b01, 16'hAB00, o_men, o_maddr, o_mwe, o_mwdata, o_lat, o_din);
        model_write(16'h7f01, 2'b01, 16'hAB00);
        access(1'b1, 16'h7f02, 1'b0, 2'b11, 16'h5555, o_men, o_maddr, o_mwe, o_mwdata, o_lat, o_din);
        model_write(16'h7f02, 2'b11, 16'h5555);
        vectors++;
        if (led !== 16'hABFF || ref_led !== 16'hABFF) begin
            miscompares++; $display("FAIL io_led_partial: got %h need abff", led);
        end
        access(1'b1, 16'h7f00, 1'b1, 2'b00, 16'h0, o_men, o_maddr, o_mwe, o_mwdata, o_lat, o_din);
        vectors++;
        if (o_din !== 16'hABFF || o_men !== 1'b0) begin
            miscompares++; $display("FAIL io_led_read: got din=%h en=%b need abff/0", o_din, o_men);
        end
        access(1'b1, 16'h7f02, 1'b1, 2'b00, 16'h0, o_men, o_maddr, o_mwe, o_mwdata, o_lat, o_din);
        vectors++;
        if (o_din !== 16'h0000 || o_lat !== 1) begin
            miscompares++; $display("FAIL io_other_read: got din=%h lat=%0d need 0000/1", o_din, o_lat);
        end
    endtask

    task automatic test_io_fetch();
        access(1'b0, 16'h7f10, 1'b0, 2'b00, 16'h0, o_men, o_maddr, o_mwe, o_mwdata, o_lat, o_din);
        vectors++;
        if (o_men !== 1'b0 || o_lat !== 1 || o_din !== 16'h0000) begin
            miscompares++; $display("FAIL io_fetch: got en=%b lat=%0d din=%h need 0/1/0000", o_men, o_lat, o_din);
        end
    endtask

    task automatic test_boundary();
        access(1'b1, 16'hffff, 1'b0, 2'b11, 16'h1357, o_men, o_maddr, o_mwe, o_mwdata, o_lat, o_din);
        model_write(16'hffff, 2'b11, 16'h1357);
        vectors++;
        if (o_maddr !== 15'h7fff || o_men !== 1'b1) begin
            miscompares++; $display("FAIL boundary_addr: got addr=%h en=%b need 7fff/1", o_maddr, o_men);
        end
        access(1'b0, 16'hfffe, 1'b0, 2'b00, 16'h0, o_men, o_maddr, o_mwe, o_mwdata, o_lat, o_din);
        vectors++;
        if (o_din !== 16'h1357 || o_maddr !== 15'h7fff) begin
            miscompares++; $display("FAIL boundary_read: got din=%h addr=%h need 1357/7fff", o_din, o_maddr);
        end
    endtask

    task automatic test_no_request();
        int seen = 0;
        @(negedge clk);
        bus.d_addr = 16'h0040; bus.d_oe = 1'b0; bus.d_we = 2'b00; bus.i_oe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (bus.m_en || bus.d_ready || bus.i_ready) seen++;
            @(negedge clk);
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++; $display("FAIL no_request: got %0d active cycles need 0", seen);
        end
    endtask

    task automatic test_conflict();
        for (int r = 0; r < 2; r++) begin
            logic [15:0] da, ia, ed, ei, gd, gi;
            int dl, il;
            bit d_first;
`ifdef ARB_ROUND_ROBIN_EN
            d_first = (ref_ptr == 1'b0);
            ref_ptr = ~ref_ptr;
`else
            d_first = 1'b1;
`endif
            da = 16'h0100 + 16'(r * 4); ia = 16'h0200 + 16'(r * 4);
            ed = exp_read(1'b1, da); ei = exp_read(1'b0, ia);
            dl = 0; il = 0; gd = 16'hxxxx; gi = 16'hxxxx;
            @(negedge clk);
            bus.d_addr = da; bus.d_oe = 1'b1; bus.d_we = 2'b00; bus.i_addr = ia; bus.i_oe = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (bus.d_ready && dl == 0) begin dl = k; gd = bus.d_din; bus.d_oe = 1'b0; end
                if (bus.i_ready && il == 0) begin il = k; gi = bus.i_din; bus.i_oe = 1'b0; end
                if (dl != 0 && il != 0) break;
            end
            bus.d_oe = 1'b0; bus.i_oe = 1'b0;
            vectors++;
            if (dl !== (d_first ? 1 : 3) || il !== (d_first ? 3 : 1)) begin
                miscompares++;
                $display("FAIL conflict_order%0d: got d_lat=%0d i_lat=%0d need %0d/%0d", r, dl, il, d_first ? 1 : 3, d_first ? 3 : 1);
            end
            vectors++;
            if (gd !== ed || gi !== ei) begin
                miscompares++; $display("FAIL conflict_data%0d: got %h/%h need %h/%h", r, gd, gi, ed, ei);
            end
        end
    endtask

    task automatic test_reset_busy();
        int lat = 0;
        logic [15:0] e, got;
        e = exp_read(1'b0, 16'h0300);
        got = 16'hxxxx;
        @(negedge clk);
        bus.i_addr = 16'h0300; bus.i_oe = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ref_led = 16'h0000; ref_ptr = 1'b0;
        #1;
        vectors++;
        if (bus.i_ready !== 1'b0 || bus.m_en !== 1'b0 || led !== ref_led) begin
            miscompares++;
            $display("FAIL reset_busy_immediate: got ready=%b en=%b led=%h need 0/0/%h", bus.i_ready, bus.m_en, led, ref_led);
        end
        @(negedge clk);
        vectors++;
        if (bus.m_en !== 1'b0 || bus.i_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_held_quiet: got en=%b ready=%b need 0/0", bus.m_en, bus.i_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.i_ready) begin lat = k; got = bus.i_din; break; end
        end
        bus.i_oe = 1'b0;
        vectors++;
        if (lat !== 1 || got !== e) begin
            miscompares++; $display("FAIL reset_rearbitrate: got lat=%0d din=%h need 1/%h", lat, got, e);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 300; n++) begin
            bit is_d, wr, oe, io;
            logic [15:0] a, v;
            logic [1:0] we;
            is_d = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = {8'h7f, 8'($urandom_range(0, 3))};
            io = is_io(a);
            wr = is_d && ($urandom_range(0, 1) == 1);
            we = wr ? 2'($urandom_range(1, 3)) : 2'b00;
            oe = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            v  = 16'($urandom);
            exp = exp_read(is_d, a);
            access(is_d, a, oe, we, v, o_men, o_maddr, o_mwe, o_mwdata, o_lat, o_din);
            if (wr) model_write(a, we, v);
            vectors++;
            if (o_lat !== 1 || o_men !== !io || o_mwe !== ((wr && !io) ? we : 2'b00)) begin
                miscompares++; bad++;
                if (bad < 10) $display("FAIL random_ctrl a=%h: got lat=%0d en=%b we=%b need 1/%b/%b", a, o_lat, o_men, o_mwe, !io, (wr && !io) ? we : 2'b00);
            end
            if (!io) begin
                vectors++;
                if (o_maddr !== a[15:1] || (wr && o_mwdata !== v)) begin
                    miscompares++; bad++;
                    if (bad < 10) $display("FAIL random_addr a=%h: got addr=%h wdata=%h need %h/%h", a, o_maddr, o_mwdata, a[15:1], v);
                end
            end
            if (!wr) begin
                vectors++;
                if (o_din !== exp) begin
                    miscompares++; bad++;
                    if (bad < 10) $display("FAIL random_read a=%h port=%s: got %h need %h", a, is_d ? "d" : "i", o_din, exp);
                end
            end
        end
        vectors++;
        if (led !== ref_led) begin
            miscompares++; $display("FAIL random_led: got %h need %h", led, ref_led);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_addr = 16'h0; bus.i_oe = 1'b0;
        bus.d_addr = 16'h0; bus.d_oe = 1'b0; bus.d_we = 2'b00; bus.d_dout = 16'h0;
        ref_led = 16'h0000; ref_ptr = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            sram[i] = b; ref_mem[i] = b;
        end
        #2;
        test_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        test_fetch();
        test_byte_write();
        test_io();
        test_io_fetch();
        test_boundary();
        test_no_request();
        test_conflict();
        test_reset_busy();
        test_conflict();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
